// File: rtl/timer_ctrl.sv
// Sequencing controller for an external WIDTH-bit timer datapath.
// It latches the period, loads and enables the counter, detects terminal count, and emits tick/done/err pulses.
module timer_ctrl #(
  parameter int WIDTH = 16,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] timer_dout,
  output logic [WIDTH-1:0] timer_din,
  output logic             timer_ld,
  output logic             timer_cnt_en,
  output logic             timer_clr,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             err,
  output logic [EXP_W-1:0] exp_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_per;
  logic             r_mode;
  logic [EXP_W-1:0] r_exp;
  logic             w_accept;
  logic             w_term;

  assign timer_din = '0;
  assign exp_cnt   = r_exp;
  // Terminal count is the last counted value; a paused cycle never expires.
  assign w_term    = (timer_dout == (r_per - WIDTH'(1))) & ~pause;

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    timer_ld     = 1'b0;
    timer_cnt_en = 1'b0;
    timer_clr    = 1'b0;
    busy         = 1'b0;
    tick         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (period != '0) begin
            w_accept = 1'b1;
            w_next   = S_LOAD;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_LOAD: begin
        busy     = 1'b1;
        timer_ld = 1'b1;
        if (stop) begin
          timer_clr = 1'b1;
          w_next    = S_IDLE;
        end else begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (stop) begin
          timer_clr = 1'b1;
          w_next    = S_IDLE;
        end else begin
          timer_cnt_en = ~pause;
          if (w_term) begin
            tick = 1'b1;
            if (r_mode) w_next   = S_DONE;
            else        timer_ld = 1'b1;
          end
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state <= S_IDLE;
      r_per   <= '0;
      r_mode  <= 1'b0;
      r_exp   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_per  <= period;
        r_mode <= oneshot;
        r_exp  <= '0;
      end else if (tick && (r_exp != '1)) begin
        r_exp <= r_exp + EXP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Randomized bench for timer_ctrl with a behavioural datapath and a countdown-based reference model.
// The model counts down the remaining un-paused RUN cycles to each expiry and never looks at timer_dout.
module tb_timer_ctrl;
  localparam int WIDTH = 16;
  localparam int EXP_W = 8;

  logic             clk = 1'b0;
  logic             aclr_n = 1'b0;
  logic             start = 1'b0, stop = 1'b0, pause = 1'b0, oneshot = 1'b0;
  logic [WIDTH-1:0] period = '0;
  logic [WIDTH-1:0] timer_dout;
  logic [WIDTH-1:0] timer_din;
  logic             timer_ld, timer_cnt_en, timer_clr, busy, tick, done, err;
  logic [EXP_W-1:0] exp_cnt;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: 0 idle, 1 load, 2 run, 3 done
  int m_ph = 0;
  int m_left = 0;
  int m_per = 0;
  int m_one = 0;
  int m_exp = 0;

  timer_ctrl #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (
    .clk(clk), .aclr_n(aclr_n), .start(start), .stop(stop), .pause(pause),
    .oneshot(oneshot), .period(period), .timer_dout(timer_dout),
    .timer_din(timer_din), .timer_ld(timer_ld), .timer_cnt_en(timer_cnt_en),
    .timer_clr(timer_clr), .busy(busy), .tick(tick), .done(done), .err(err),
    .exp_cnt(exp_cnt)
  );

  always #5 clk = ~clk;

  // Timer datapath: clear, then load, then count.
  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n)           timer_dout <= '0;
    else if (timer_clr)    timer_dout <= '0;
    else if (timer_ld)     timer_dout <= timer_din;
    else if (timer_cnt_en) timer_dout <= timer_dout + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, check the outputs, then advance the model across the edge.
  task automatic step(input logic st, input logic sp, input logic pa, input logic os,
                      input logic [WIDTH-1:0] per);
    int e_ld, e_en, e_clr, e_busy, e_tick, e_done, e_err;
    @(negedge clk);
    start = st; stop = sp; pause = pa; oneshot = os; period = per;
    #1;
    e_ld = 0; e_en = 0; e_clr = 0; e_busy = 0; e_tick = 0; e_done = 0; e_err = 0;
    case (m_ph)
      0: e_err = (st && per == 0) ? 1 : 0;
      1: begin e_busy = 1; e_ld = 1; e_clr = sp ? 1 : 0; end
      2: begin
        e_busy = 1;
        if (sp) e_clr = 1;
        else begin
          e_en   = pa ? 0 : 1;
          e_tick = (!pa && m_left == 1) ? 1 : 0;
          e_ld   = (e_tick == 1 && m_one == 0) ? 1 : 0;
        end
      end
      default: e_done = 1;
    endcase
    chk("timer_ld", 32'(timer_ld), 32'(e_ld));
    chk("cnt_en",   32'(timer_cnt_en), 32'(e_en));
    chk("timer_clr",32'(timer_clr), 32'(e_clr));
    chk("busy",     32'(busy), 32'(e_busy));
    chk("tick",     32'(tick), 32'(e_tick));
    chk("done",     32'(done), 32'(e_done));
    chk("err",      32'(err), 32'(e_err));
    chk("exp_cnt",  32'(exp_cnt), 32'(m_exp));
    chk("timer_din",32'(timer_din), 32'd0);
    case (m_ph)
      0: if (st && per != 0) begin
        m_per = int'(per); m_one = os ? 1 : 0; m_exp = 0; m_ph = 1;
      end
      1: begin m_ph = sp ? 0 : 2; m_left = m_per; end
      2: begin
        if (sp) m_ph = 0;
        else if (!pa) begin
          if (m_left == 1) begin
            if (m_exp < 255) m_exp++;
            if (m_one == 1) m_ph = 3;
            else m_left = m_per;
          end else m_left--;
        end
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic do_reset();
    @(negedge clk);
    aclr_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    #1;
    chk("rst_ld",   32'(timer_ld), 32'd0);
    chk("rst_en",   32'(timer_cnt_en), 32'd0);
    chk("rst_clr",  32'(timer_clr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err",  32'(err), 32'd0);
    chk("rst_exp",  32'(exp_cnt), 32'd0);
    m_ph = 0; m_exp = 0; m_left = 0; m_per = 0; m_one = 0;
    #2 aclr_n = 1'b1;
  endtask

  initial begin
    do_reset();
    // Directed one-shot, period 4
    step(1, 0, 0, 1, 16'd4);
    repeat (8) step(0, 0, 0, 0, 16'd0);
    // Directed periodic, period 3, with a pause, a rejected start and an ignored restart
    step(1, 0, 0, 0, 16'd0);
    step(1, 0, 0, 0, 16'd3);
    repeat (6) step(0, 0, 0, 0, 16'd0);
    repeat (2) step(0, 0, 1, 0, 16'd0);
    step(1, 0, 0, 0, 16'd9);
    repeat (8) step(0, 0, 0, 0, 16'd0);
    step(0, 1, 0, 0, 16'd0);
    // Stop during LOAD
    step(1, 0, 0, 0, 16'd5);
    step(0, 1, 0, 0, 16'd0);
    step(0, 0, 0, 0, 16'd0);
    // Saturation: period 1 ticks every RUN cycle
    step(1, 0, 0, 0, 16'd1);
    repeat (300) step(0, 0, 0, 0, 16'd0);
    chk("exp_sat", 32'(exp_cnt), 32'd255);
    step(0, 1, 0, 0, 16'd0);
    // Reset mid-run
    step(1, 0, 0, 0, 16'd5);
    repeat (5) step(0, 0, 0, 0, 16'd0);
    do_reset();
    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic st, sp, pa, os;
      logic [WIDTH-1:0] per;
      st  = ($urandom_range(0, 9) == 0);
      sp  = ($urandom_range(0, 39) == 0);
      pa  = ($urandom_range(0, 5) == 0);
      os  = $urandom_range(0, 1) == 1;
      per = ($urandom_range(0, 7) == 0) ? 16'd0 : WIDTH'($urandom_range(1, 7));
      step(st, sp, pa, os, per);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
